// File: rtl/uart_tx_if.sv
// Upstream byte handshake for uart_tx: the producer drives data/valid, the transmitter drives ready.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// Parity stage is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave tx_if,
  output logic     serial_out,
  output logic     tx_busy
);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  localparam bit parity_odd_unused = PARITY_ODD;
`endif

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 hs, bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign tx_if.tx_ready = (state_q == IDLE);
  assign tx_busy        = (state_q != IDLE);
  assign serial_out     = serial_q;
  assign hs             = tx_if.tx_valid & tx_if.tx_ready;
  assign bit_done       = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    // Divider free-runs inside a frame; every state below only acts on bit_done.
    if (state_q != IDLE) div_d = bit_done ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (hs) begin
          shift_d = tx_if.tx_data;
          state_d = START;
          div_d   = '0;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          // Parity taken from the byte at latch time since the shifter consumes it.
          par_d   = (^tx_if.tx_data) ^ PARITY_ODD;
`endif
        end
      end
      START: if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      STOP: begin
        if (bit_done) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value is derived from the next state so serial_out is a pure register.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = par_d;
`endif
      default: serial_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboarded line decoder on an 8N1/4x instance plus a 7-bit, 2-stop, 16x instance.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB = 4;
  localparam int NB  = 1 + 8 + P + 1;
  localparam int FL  = NB * CPB;
  localparam int CPB2 = 16;
  localparam int NB2  = 1 + 7 + P + 2;
  localparam int FL2  = NB2 * CPB2;

  logic clk = 1'b0;
  logic rst_n;
  logic serial_out, tx_busy, s2, busy2;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(8)) u_if ();
  uart_tx_if #(.DATA_BITS(7)) if2 ();

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_if(u_if.slave), .serial_out(serial_out), .tx_busy(tx_busy));
  uart_tx #(.CLKS_PER_BIT(CPB2), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_if(if2.slave), .serial_out(s2), .tx_busy(busy2));

  int checks = 0, errors = 0;
  int frames = 0, exp_frames = 0, hs_cnt = 0;
  logic [7:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Line decoder: one frame starts at the first low cycle, k counts cycles into it.
  logic mon_act = 1'b0;
  int   k, hold_err, busy_err;
  logic bits [NB];
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0;
      sb_q.delete();
    end else begin
      if (u_if.tx_valid && u_if.tx_ready) begin
        sb_q.push_back(u_if.tx_data);
        hs_cnt++;
      end
      if (!mon_act && !serial_out) begin
        mon_act = 1'b1; k = 0; hold_err = 0; busy_err = 0;
      end
      if (mon_act) begin
        if (k == FL) begin
          chk("idle_gap", {serial_out, u_if.tx_ready, tx_busy}, 3'b110);
          mon_act = 1'b0;
        end else begin
          if (k % CPB == 0) bits[k / CPB] = serial_out;
          else if (serial_out !== bits[k / CPB]) hold_err++;
          if (!tx_busy) busy_err++;
          if (k == FL - 1) begin
            logic [7:0] got, exp;
            for (int i = 0; i < 8; i++) got[i] = bits[1 + i];
            chk("start_bit", bits[0], 1'b0);
            chk("stop_bit", bits[NB-1], 1'b1);
            chk("bit_hold", hold_err, 0);
            chk("busy_in_frame", busy_err, 0);
            if (sb_q.size() == 0) chk("sb_empty", 1, 0);
            else begin
              exp = sb_q.pop_front();
              chk("data", got, exp);
`ifdef UART_TX_PARITY_EN
              chk("parity", bits[9], ^exp);
`endif
            end
            frames++;
          end
          k++;
        end
      end
    end
  end

  task automatic send_hs(input logic [7:0] d);
    bit ok = 0;
    u_if.tx_data  = d;
    u_if.tx_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (u_if.tx_ready) ok = 1;
    end
    if (!ok) chk("hs_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      n++;
      if (u_if.tx_ready) break;
    end
  endtask

  initial begin
    int n, viol, h0, lerr, berr, gap;
    logic [6:0] d2;
    logic exp2 [NB2];
    rst_n = 1'b0;
    u_if.tx_valid = 1'b0; u_if.tx_data = '0;
    if2.tx_valid = 1'b0;  if2.tx_data = '0;
    @(posedge clk); #1;
    chk("rst_state", {serial_out, u_if.tx_ready, tx_busy}, 3'b110);
    chk("rst_state2", {s2, if2.tx_ready, busy2}, 3'b110);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    viol = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if ({serial_out, u_if.tx_ready, tx_busy} !== 3'b110) viol++;
    end
    chk("idle20", viol, 0);

    // Single frame: start bit right after the handshake edge, ready back after FL cycles.
    send_hs(8'hA5); exp_frames++;
    u_if.tx_valid = 1'b0;
    chk("start_lat", {serial_out, u_if.tx_ready, tx_busy}, 3'b001);
    wait_ready(n);
    chk("ready_ret", n, FL);
    repeat (3) @(posedge clk); #1;

    // Back-to-back with valid held; data change mid-frame must be ignored.
    h0 = hs_cnt;
    send_hs(8'h00); exp_frames++;
    u_if.tx_data = 8'hFF;
    wait_ready(n);
    chk("b2b_gap", n, FL);
    chk("b2b_idle_line", serial_out, 1'b1);
    @(posedge clk); #1;
    exp_frames++;
    u_if.tx_valid = 1'b0;
    chk("b2b_start", {serial_out, tx_busy}, 2'b01);
    wait_ready(n);
    chk("b2b_ret", n, FL);
    chk("b2b_hs", hs_cnt - h0, 2);
    repeat (2) @(posedge clk); #1;

    // Abort mid-frame with a one-cycle reset.
    send_hs(8'h11);
    u_if.tx_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_state", {serial_out, u_if.tx_ready, tx_busy}, 3'b110);
    send_hs(8'h3C); exp_frames++;
    u_if.tx_valid = 1'b0;
    wait_ready(n);
    chk("after_abort_ret", n, FL);

    send_hs(8'hA5); exp_frames++;
    u_if.tx_valid = 1'b0;
    wait_ready(n);
    send_hs(8'h07); exp_frames++;
    u_if.tx_valid = 1'b0;
    wait_ready(n);

    for (int r = 0; r < 6; r++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #1;
      send_hs(8'($urandom)); exp_frames++;
      u_if.tx_valid = 1'b0;
      wait_ready(n);
    end

    // Wide instance: 7 data bits, odd parity when compiled, two stop bits at 16x.
    d2 = 7'h55;
    exp2[0] = 1'b0;
    for (int i = 0; i < 7; i++) exp2[1 + i] = d2[i];
`ifdef UART_TX_PARITY_EN
    exp2[8] = ~^d2;
`endif
    exp2[NB2-2] = 1'b1;
    exp2[NB2-1] = 1'b1;
    if2.tx_data = d2;
    if2.tx_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if2.tx_ready) begin n = 1; break; end
    end
    chk("hs2", n, 1);
    @(posedge clk); #1;
    if2.tx_valid = 1'b0;
    lerr = 0; berr = 0;
    for (int c = 0; c < FL2; c++) begin
      if (s2 !== exp2[c / CPB2]) lerr++;
      if (!busy2) berr++;
      @(posedge clk); #1;
    end
    chk("f2_line", lerr, 0);
    chk("f2_busy", berr, 0);
    chk("f2_end", {s2, if2.tx_ready, busy2}, 3'b110);

    repeat (4) @(posedge clk); #1;
    chk("sb_drain", sb_q.size(), 0);
    chk("frame_count", frames, exp_frames);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
